// File: rtl/apb_master_arbiter_if.sv
// Request/response handshake and APB master bus of the two-port APB arbiter.
// The master modport is the arbiter's view; the slave modport is everything around it.
interface apb_master_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_write;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  pready, prdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output pready, prdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that serves two register requesters over a single APB master port,
// with an optional ACCESS-phase timeout that reports an error response.
module apb_master_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                  clk,
    input logic                  rst,
    apb_master_arbiter_if.master bus
);
    localparam int unsigned     CntW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned     TimeoutLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CntW-1:0] CntLast     = CntW'(TimeoutLast);
    localparam logic [CntW-1:0] CntMax      = '1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic       grant;
    logic       idle;
    logic [1:0] ready;
    logic       accept;
    logic       expired;

    // Contention goes to the requester that was not served last.
    assign grant    = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant_q);
    assign idle     = (state_q == StIdle) && !rst;
    assign ready[0] = idle & bus.req_valid[0] & ~grant;
    assign ready[1] = idle & grant;
    assign accept   = |ready;
    assign expired  = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rsp_valid_d  = 2'b00;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d      = StSetup;
                    last_grant_d = grant;
                    owner_d      = grant;
                    psel_d       = 1'b1;
                    pwrite_d     = bus.req_write[grant];
                    paddr_d      = grant ? bus.req_addr1 : bus.req_addr0;
                    pwdata_d     = grant ? bus.req_wdata1 : bus.req_wdata0;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            StAccess: begin
                // pready in the expiry cycle still counts as a normal completion.
                if (bus.pready || expired) begin
                    state_d              = StIdle;
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    pwrite_d             = 1'b0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d            = ~bus.pready;
                    rsp_rdata_d          = (bus.pready && !pwrite_q) ? bus.prdata : '0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: a transaction-level model predicts, from accept cycle and
// wait-state count, when each APB phase and each response must appear.
module tb_apb_master_arbiter;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    apb_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Pending requests per requester
    int          pend [2];
    bit          r_write [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    int          r_wait [2];
    bit          r_rand, r_gap, use_fix;
    int          wait_max;
    logic [31:0] fix_rdata;

    // Reference model: one transfer described by its accept cycle and ACCESS length
    bit          lg;
    int          idle_at, x_acc, x_n;
    bit          x_to, x_write;
    logic [31:0] x_rdata, h_addr, h_wdata;
    bit          rp_pend, rp_port, rp_err;
    int          rp_cyc;
    logic [31:0] rp_data;

    // DUT observations for scenario-level checks
    int          obs_acc[$];
    int          obs_grant[$];
    int          obs_rsp_cyc[$];
    bit          obs_rsp_err[$];
    logic [31:0] obs_rsp_data[$];
    int          obs_access, cur_gap, max_gap;
    bit          seen_psel;

    task automatic clear_obs();
        obs_acc.delete(); obs_grant.delete(); obs_rsp_cyc.delete();
        obs_rsp_err.delete(); obs_rsp_data.delete();
        obs_access = 0; cur_gap = 0; max_gap = 0; seen_psel = 0;
    endtask

    task automatic new_req(input int p);
        r_write[p] = 1'($urandom_range(0, 1));
        r_addr[p]  = $urandom & 32'h0000_00FC;
        r_wdata[p] = $urandom;
        r_wait[p]  = int'($urandom_range(0, wait_max));
    endtask

    task automatic set_req(input int p, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input int ws);
        r_write[p] = w; r_addr[p] = a; r_wdata[p] = d; r_wait[p] = ws; pend[p] = 1;
    endtask

    // One clock cycle: drive at the falling edge, score against the model, advance the model.
    task automatic step(input bit do_rst);
        int         t, n, p;
        logic [1:0] v, er, ev;
        logic [2:0] ectl, actl;
        bit         g, ep, in_acc, last_acc;
        t = cyc;
        for (int i = 0; i < 2; i++)
            v[i] = (pend[i] > 0) && (!r_gap || $urandom_range(0, 3) != 0);
        rst            = do_rst;
        bus.req_valid  = v;
        bus.req_write  = {r_write[1], r_write[0]};
        bus.req_addr0  = r_addr[0];
        bus.req_addr1  = r_addr[1];
        bus.req_wdata0 = r_wdata[0];
        bus.req_wdata1 = r_wdata[1];
        in_acc   = (t >= x_acc + 2) && (t <= x_acc + 1 + x_n);
        last_acc = (t == x_acc + 1 + x_n);
        bus.pready = in_acc ? (last_acc && !x_to) : 1'($urandom_range(0, 1));
        bus.prdata = (in_acc && last_acc) ? x_rdata : $urandom;
        #1;
        g  = v[1] && (!v[0] || !lg);
        er = (do_rst || t < idle_at || v == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01);
        vectors++;
        if (bus.req_ready !== er) begin
            miscompares++;
            $display("FAIL req_ready @%0d: got %b want %b", t, bus.req_ready, er);
        end
        ep   = (t >= x_acc + 1) && (t <= x_acc + 1 + x_n);
        ectl = {ep, ep && (t >= x_acc + 2), ep && x_write};
        actl = {bus.psel, bus.penable, bus.pwrite};
        vectors++;
        if (actl !== ectl) begin
            miscompares++;
            $display("FAIL psel/penable/pwrite @%0d: got %b want %b", t, actl, ectl);
        end
        vectors++;
        if (bus.paddr !== h_addr || bus.pwdata !== h_wdata) begin
            miscompares++;
            $display("FAIL paddr/pwdata @%0d: got %h/%h want %h/%h", t, bus.paddr, bus.pwdata,
                     h_addr, h_wdata);
        end
        ev = (rp_pend && rp_cyc == t) ? (rp_port ? 2'b10 : 2'b01) : 2'b00;
        vectors++;
        if (bus.rsp_valid !== ev) begin
            miscompares++;
            $display("FAIL rsp_valid @%0d: got %b want %b", t, bus.rsp_valid, ev);
        end
        if (ev != 2'b00) begin
            vectors++;
            if ({bus.rsp_err, bus.rsp_rdata} !== {rp_err, rp_data}) begin
                miscompares++;
                $display("FAIL rsp_err/rdata @%0d: got %b/%h want %b/%h", t, bus.rsp_err,
                         bus.rsp_rdata, rp_err, rp_data);
            end
            rp_pend = 0;
        end
        if ((bus.req_valid & bus.req_ready) != 2'b00) begin
            obs_acc.push_back(t);
            obs_grant.push_back(int'(bus.req_ready[1]));
        end
        if (bus.rsp_valid != 2'b00) begin
            obs_rsp_cyc.push_back(t);
            obs_rsp_err.push_back(bus.rsp_err);
            obs_rsp_data.push_back(bus.rsp_rdata);
        end
        if (bus.psel === 1'b1 && bus.penable === 1'b1) obs_access++;
        if (bus.psel === 1'b1) begin
            if (seen_psel && cur_gap > max_gap) max_gap = cur_gap;
            seen_psel = 1; cur_gap = 0;
        end else begin
            cur_gap++;
        end
        if (er != 2'b00) begin
            p       = er[1] ? 1 : 0;
            x_to    = r_wait[p] >= int'(TIMEOUT);
            n       = x_to ? int'(TIMEOUT) : r_wait[p] + 1;
            x_acc   = t; x_n = n; x_write = r_write[p];
            h_addr  = r_addr[p]; h_wdata = r_wdata[p];
            x_rdata = use_fix ? fix_rdata : $urandom;
            lg      = p[0];
            idle_at = t + 2 + n;
            rp_pend = 1; rp_cyc = t + 2 + n; rp_port = p[0]; rp_err = x_to;
            rp_data = (x_to || x_write) ? 32'h0 : x_rdata;
            pend[p]--;
            if (r_rand) new_req(p);
        end
        if (do_rst) begin
            x_acc = -1000; x_n = 0; rp_pend = 0; idle_at = t + 1; lg = 1;
            h_addr = '0; h_wdata = '0;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        bit done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            if (pend[0] == 0 && pend[1] == 0 && !rp_pend) done = 1;
            else step(1'b0);
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL drain: got unfinished after %0d cycles want idle", max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11; bus.req_write = 2'b11;
        bus.req_addr0 = 32'h10; bus.req_addr1 = 32'h20;
        bus.req_wdata0 = 32'h1; bus.req_wdata1 = 32'h2;
        bus.pready = 1'b1; bus.prdata = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (bus.req_ready !== 2'b00) begin
            miscompares++; $display("FAIL reset req_ready: got %b want 00", bus.req_ready);
        end
        vectors++;
        if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset apb ctl: got %b want 000", {bus.psel, bus.penable, bus.pwrite});
        end
        vectors++;
        if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset paddr/pwdata: got %h/%h want 0/0", bus.paddr, bus.pwdata);
        end
        vectors++;
        if (bus.rsp_valid !== 2'b00 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset rsp: got %b/%b/%h want 00/0/0", bus.rsp_valid, bus.rsp_err,
                     bus.rsp_rdata);
        end
        lg = 1; idle_at = cyc; x_acc = -1000; x_n = 0; rp_pend = 0;
        h_addr = '0; h_wdata = '0;
    endtask

    task automatic test_single_write();
        clear_obs();
        set_req(0, 1'b1, 32'h04, 32'hA5, 0);
        drain(20);
        vectors++;
        if (obs_rsp_cyc.size() != 1 || obs_acc.size() != 1 ||
            obs_rsp_cyc[0] - obs_acc[0] != 3 || obs_rsp_err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_write latency: got %0d rsp entries want 1 at +3, err 0",
                     obs_rsp_cyc.size());
        end
    endtask

    task automatic test_read_wait();
        clear_obs();
        use_fix = 1; fix_rdata = 32'h1234_5678;
        set_req(1, 1'b0, 32'h08, 32'h0, 3);
        drain(30);
        use_fix = 0;
        vectors++;
        if (obs_access != 4) begin
            miscompares++; $display("FAIL read_wait access cycles: got %0d want 4", obs_access);
        end
        vectors++;
        if (obs_rsp_data.size() != 1 || obs_rsp_data[0] !== 32'h1234_5678) begin
            miscompares++; $display("FAIL read_wait rdata: got %0d responses want 1 of 12345678",
                                    obs_rsp_data.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        wait_max = 0; r_rand = 1;
        new_req(0); new_req(1);
        pend[0] = 4; pend[1] = 4;
        drain(100);
        r_rand = 0;
        vectors++;
        if (obs_grant.size() != 8) begin
            miscompares++; $display("FAIL rr count: got %0d want 8", obs_grant.size());
        end
        for (int i = 0; i < obs_grant.size(); i++) begin
            vectors++;
            if (obs_grant[i] != i % 2) begin
                miscompares++;
                $display("FAIL rr grant %0d: got %0d want %0d", i, obs_grant[i], i % 2);
            end
        end
        for (int i = 1; i < obs_acc.size(); i++) begin
            vectors++;
            if (obs_acc[i] - obs_acc[i-1] != 3) begin
                miscompares++;
                $display("FAIL rr spacing %0d: got %0d want 3", i, obs_acc[i] - obs_acc[i-1]);
            end
        end
        vectors++;
        if (max_gap > 1) begin
            miscompares++; $display("FAIL rr psel gap: got %0d want <=1", max_gap);
        end
    endtask

    task automatic test_timeout();
        clear_obs();
        set_req(0, 1'b0, 32'h0C, 32'h0, 1000);
        drain(40);
        vectors++;
        if (obs_access != 16) begin
            miscompares++; $display("FAIL timeout access cycles: got %0d want 16", obs_access);
        end
        vectors++;
        if (obs_rsp_err.size() != 1 || obs_rsp_err[0] !== 1'b1 || obs_rsp_data[0] !== 32'h0) begin
            miscompares++; $display("FAIL timeout rsp: got %0d responses want 1 with err=1 data=0",
                                    obs_rsp_err.size());
        end
        clear_obs();
        set_req(1, 1'b1, 32'h10, 32'h55, 2);
        drain(20);
        vectors++;
        if (obs_rsp_err.size() != 1 || obs_rsp_err[0] !== 1'b0 ||
            obs_rsp_cyc[0] - obs_acc[0] != 5) begin
            miscompares++; $display("FAIL after_timeout rsp: got %0d responses want 1 ok at +5",
                                    obs_rsp_err.size());
        end
    endtask

    task automatic test_expiry_ready();
        clear_obs();
        use_fix = 1; fix_rdata = 32'hCAFE_F00D;
        set_req(0, 1'b0, 32'h14, 32'h0, 15);
        drain(40);
        use_fix = 0;
        vectors++;
        if (obs_access != 16) begin
            miscompares++; $display("FAIL expiry access cycles: got %0d want 16", obs_access);
        end
        vectors++;
        if (obs_rsp_err.size() != 1 || obs_rsp_err[0] !== 1'b0 ||
            obs_rsp_data[0] !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL expiry rsp: got %0d responses want 1 ok with CAFEF00D",
                                    obs_rsp_err.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        set_req(0, 1'b0, 32'h18, 32'h0, 10);
        for (int i = 0; i < 20 && obs_access < 2; i++) step(1'b0);
        step(1'b1);
        repeat (15) step(1'b0);
        vectors++;
        if (obs_rsp_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid rsp: got %0d responses want 0", obs_rsp_cyc.size());
        end
        clear_obs();
        set_req(0, 1'b1, 32'h1C, 32'h11, 0);
        set_req(1, 1'b1, 32'h20, 32'h22, 0);
        drain(30);
        vectors++;
        if (obs_grant.size() != 2 || obs_grant[0] != 0) begin
            miscompares++; $display("FAIL reset_mid first grant: got %0d grants want requester 0",
                                    obs_grant.size());
        end
    endtask

    task automatic test_random();
        clear_obs();
        wait_max = 20; r_rand = 1; r_gap = 1;
        new_req(0); new_req(1);
        pend[0] = 20; pend[1] = 20;
        drain(2000);
        r_rand = 0; r_gap = 0;
        vectors++;
        if (obs_rsp_cyc.size() != 40) begin
            miscompares++; $display("FAIL random rsp count: got %0d want 40", obs_rsp_cyc.size());
        end
    endtask

    initial begin
        pend[0] = 0; pend[1] = 0;
        r_rand = 0; r_gap = 0; use_fix = 0; wait_max = 0; fix_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            r_write[i] = 0; r_addr[i] = '0; r_wdata[i] = '0; r_wait[i] = 0;
        end
        x_to = 0; x_write = 0; x_rdata = '0; rp_port = 0; rp_err = 0; rp_cyc = 0;
        rp_data = '0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_expiry_ready();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test want finish before time limit");
        $fatal(1);
    end
endmodule
